// File: rtl/reg_a_gen_if.sv
// Control and result bundle for the reg_a_gen accumulator.
// The controller drives the master side; the accumulator sits on the slave side.
interface reg_a_gen_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             c0;
    logic             c1;
    logic             c2;
    logic             c4;
    logic             c5;
    logic             c6;
    logic             shl_in;
    logic [WIDTH-1:0] inbus;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] q;
    logic             a_lsb;
    logic             a_msb;
    logic [CNT_W-1:0] cnt;
    logic             cnt_done;
    logic             zero;
    logic             neg;

    modport master (
        output c0, c1, c2, c4, c5, c6, shl_in, inbus, sum,
        input  q, a_lsb, a_msb, cnt, cnt_done, zero, neg
    );

    modport slave (
        input  c0, c1, c2, c4, c5, c6, shl_in, inbus, sum,
        output q, a_lsb, a_msb, cnt, cnt_done, zero, neg
    );
endinterface

// File: rtl/reg_a_gen.sv
// Shifting accumulator with load, arithmetic-right / logical-left shift,
// saturating shift counter and a tri-state read-out bus.
module reg_a_gen #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    reg_a_gen_if.slave       bus,
    output wire [WIDTH-1:0]  o_obus
);
    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_lsb;
    logic             r_msb;

    logic [WIDTH-1:0] w_q_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_lsb_nxt;
    logic             w_msb_nxt;
    logic             w_cnt_full;

    assign w_cnt_full = (r_cnt >= CNT_W'(WIDTH));
    assign w_cnt_inc  = w_cnt_full ? r_cnt : r_cnt + CNT_W'(1);

    // Strict priority: only the highest asserted control acts on an edge.
    always_comb begin
        w_q_nxt   = r_q;
        w_cnt_nxt = r_cnt;
        w_lsb_nxt = r_lsb;
        w_msb_nxt = r_msb;
        if (bus.c0) begin
            w_q_nxt   = '0;
            w_cnt_nxt = '0;
            w_lsb_nxt = 1'b0;
            w_msb_nxt = 1'b0;
        end else if (bus.c1) begin
            w_q_nxt = bus.inbus;
        end else if (bus.c2) begin
            w_q_nxt = bus.sum;
        end else if (bus.c4) begin
            w_q_nxt   = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
            w_lsb_nxt = r_q[0];
            w_cnt_nxt = w_cnt_inc;
        end else if (bus.c6) begin
            w_q_nxt   = {r_q[WIDTH-2:0], bus.shl_in};
            w_msb_nxt = r_q[WIDTH-1];
            w_cnt_nxt = w_cnt_inc;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q   <= '0;
            r_cnt <= '0;
            r_lsb <= 1'b0;
            r_msb <= 1'b0;
        end else begin
            r_q   <= w_q_nxt;
            r_cnt <= w_cnt_nxt;
            r_lsb <= w_lsb_nxt;
            r_msb <= w_msb_nxt;
        end
    end

    assign bus.q        = r_q;
    assign bus.cnt      = r_cnt;
    assign bus.a_lsb    = r_lsb;
    assign bus.a_msb    = r_msb;
    assign bus.cnt_done = (r_cnt == CNT_W'(WIDTH));
    assign bus.zero     = (r_q == '0);
    assign bus.neg      = r_q[WIDTH-1];

    // Read-out enable is independent of reset and of the other controls.
    assign o_obus = bus.c5 ? r_q : {WIDTH{1'bz}};
endmodule

// File: tb/tb_reg_a_gen.sv
// Self-checking bench for reg_a_gen: directed vector table, counter and reset
// sequences on an 8-bit and a 16-bit instance, then random stimulus vs. a model.
module tb_reg_a_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    reg_a_gen_if #(.WIDTH(8),  .CNT_W(4)) b8 ();
    reg_a_gen_if #(.WIDTH(16), .CNT_W(5)) b16 ();
    wire [7:0]  obus8;
    wire [15:0] obus16;

    reg_a_gen #(.WIDTH(8), .CNT_W(4)) dut8 (
        .i_clk(clk), .i_rst(rst), .bus(b8), .o_obus(obus8));
    reg_a_gen #(.WIDTH(16), .CNT_W(5)) dut16 (
        .i_clk(clk), .i_rst(rst), .bus(b16), .o_obus(obus16));

    typedef struct {
        logic       c0, c1, c2, c4, c6, shl;
        logic [7:0] inbus, sum;
        logic [7:0] e_q;
        int         e_cnt;
        logic       e_lsb, e_msb;
    } vec_t;
    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set8(input logic c0, c1, c2, c4, c6, shl,
                        input logic [7:0] inbus, sum);
        b8.c0 = c0; b8.c1 = c1; b8.c2 = c2; b8.c4 = c4; b8.c6 = c6;
        b8.shl_in = shl; b8.inbus = inbus; b8.sum = sum;
    endtask

    task automatic set16(input logic c0, c1, c2, c4, c6,
                         input logic [15:0] inbus, sum);
        b16.c0 = c0; b16.c1 = c1; b16.c2 = c2; b16.c4 = c4; b16.c6 = c6;
        b16.shl_in = 1'b0; b16.inbus = inbus; b16.sum = sum;
    endtask

    task automatic chk8(input string tag, input logic [7:0] q, input int cnt,
                        input logic lsb, input logic msb);
        chk({tag, ".q"},     32'(b8.q),        32'(q));
        chk({tag, ".cnt"},   32'(b8.cnt),      32'(cnt));
        chk({tag, ".lsb"},   32'(b8.a_lsb),    32'(lsb));
        chk({tag, ".msb"},   32'(b8.a_msb),    32'(msb));
        chk({tag, ".zero"},  32'(b8.zero),     32'(q == 8'h00));
        chk({tag, ".neg"},   32'(b8.neg),      32'(q >= 8'h80));
        chk({tag, ".done"},  32'(b8.cnt_done), 32'(cnt == 8));
    endtask

    // Reference model state (8-bit instance), integer arithmetic.
    int m_q, m_cnt, m_lsb, m_msb;

    task automatic model_step(input logic c0, c1, c2, c4, c6, shl,
                              input logic [7:0] inbus, sum);
        int sq;
        if (c0) begin
            m_q = 0; m_cnt = 0; m_lsb = 0; m_msb = 0;
        end else if (c1) m_q = int'(inbus);
        else if (c2) m_q = int'(sum);
        else if (c4) begin
            m_lsb = m_q % 2;
            sq = (m_q >= 128) ? m_q - 256 : m_q;
            if (sq < 0) sq = -((1 - sq) / 2);  // floor division by two
            else sq = sq / 2;
            m_q = (sq + 256) % 256;
            m_cnt = (m_cnt < 8) ? m_cnt + 1 : 8;
        end else if (c6) begin
            m_msb = m_q / 128;
            m_q = (m_q * 2 + int'(shl)) % 256;
            m_cnt = (m_cnt < 8) ? m_cnt + 1 : 8;
        end
    endtask

    initial begin
        logic [7:0]  zz8;
        logic [15:0] exp16;
        logic        r_c0, r_c1, r_c2, r_c4, r_c6, r_shl;
        logic [7:0]  r_in, r_sum;
        zz8 = 8'bz;

        vt[0]  = '{1,0,0,0,0,0, 8'h00, 8'h00, 8'h00, 0, 0, 0};
        vt[1]  = '{0,0,1,0,0,0, 8'h00, 8'h96, 8'h96, 0, 0, 0};
        vt[2]  = '{0,0,0,1,0,0, 8'h00, 8'h00, 8'hCB, 1, 0, 0};
        vt[3]  = '{0,0,0,1,0,0, 8'h00, 8'h00, 8'hE5, 2, 1, 0};
        vt[4]  = '{0,1,0,0,0,0, 8'h81, 8'h00, 8'h81, 2, 1, 0};
        vt[5]  = '{0,0,0,0,1,1, 8'h00, 8'h00, 8'h03, 3, 1, 1};
        vt[6]  = '{1,1,1,0,0,0, 8'h55, 8'hAA, 8'h00, 0, 0, 0};
        vt[7]  = '{0,1,1,0,0,0, 8'h55, 8'hAA, 8'h55, 0, 0, 0};
        vt[8]  = '{0,0,1,1,0,0, 8'h00, 8'h7F, 8'h7F, 0, 0, 0};
        vt[9]  = '{0,0,0,1,0,0, 8'h00, 8'h00, 8'h3F, 1, 1, 0};
        vt[10] = '{0,0,0,0,1,0, 8'h00, 8'h00, 8'h7E, 2, 1, 0};
        vt[11] = '{0,0,0,0,0,1, 8'hFF, 8'hFF, 8'h7E, 2, 1, 0};

        set8(0,0,0,0,0,0, 8'h00, 8'h00);
        set16(0,0,0,0,0, 16'h0, 16'h0);
        b8.c5 = 1'b1; b16.c5 = 1'b0;
        b8.c1 = 1'b1; b8.inbus = 8'hA5;
        #12;
        chk8("reset", 8'h00, 0, 0, 0);
        chk("reset.obus_c5", 32'(obus8), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        set8(0,0,0,0,0,0, 8'h00, 8'h00);

        for (int i = 0; i < 12; i++) begin
            set8(vt[i].c0, vt[i].c1, vt[i].c2, vt[i].c4, vt[i].c6, vt[i].shl,
                 vt[i].inbus, vt[i].sum);
            tick();
            chk8($sformatf("vec%0d", i), vt[i].e_q, vt[i].e_cnt, vt[i].e_lsb, vt[i].e_msb);
        end

        // Bus read-out follows c5 alone; q is 7E here.
        b8.c5 = 1'b0; #1;
        chk("obus_off", 32'((obus8 === zz8) || (obus8 === 8'h00)), 32'h1);
        b8.c5 = 1'b1; #1;
        chk("obus_on", 32'(obus8), 32'h7E);

        // Counter saturation with the shift still applied.
        set8(1,0,0,0,0,0, 8'h00, 8'h00); tick();
        set8(0,0,0,1,0,0, 8'h00, 8'h00);
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk($sformatf("sat8.cnt%0d", i), 32'(b8.cnt), 32'((i < 8) ? i : 8));
            chk($sformatf("sat8.done%0d", i), 32'(b8.cnt_done), 32'(i >= 8));
        end
        set8(1,0,0,0,0,0, 8'h00, 8'h00); tick();
        chk8("sat8.clr", 8'h00, 0, 0, 0);

        // Build q=7F, cnt=3, then async reset between edges.
        set8(0,0,0,0,1,0, 8'h00, 8'h00); tick(); tick(); tick();
        set8(0,1,0,0,0,0, 8'h7F, 8'h00); tick();
        chk8("prerst", 8'h7F, 3, 0, 0);
        set8(0,0,0,0,0,0, 8'h00, 8'h00);
        @(negedge clk); #2;
        rst = 1'b1; #1;
        chk8("async_rst", 8'h00, 0, 0, 0);
        chk("rst.obus_c5", 32'(obus8), 32'h0);
        set8(0,1,0,0,0,0, 8'h12, 8'h00); tick();
        chk("rst_hold.q", 32'(b8.q), 32'h0);
        rst = 1'b0;
        tick();
        chk("rst_release.q", 32'(b8.q), 32'h12);

        // 16-bit instance: sign shift and counter saturation at 16.
        set8(0,0,0,0,0,0, 8'h00, 8'h00);
        set16(0,0,1,0,0, 16'h0, 16'h8096); tick();
        chk("w16.load", 32'(b16.q), 32'h8096);
        set16(0,0,0,1,0, 16'h0, 16'h0); tick();
        chk("w16.sh1.q", 32'(b16.q), 32'hC04B);
        chk("w16.sh1.lsb", 32'(b16.a_lsb), 32'h0);
        chk("w16.sh1.cnt", 32'(b16.cnt), 32'h1);
        tick();
        chk("w16.sh2.q", 32'(b16.q), 32'hE025);
        chk("w16.sh2.lsb", 32'(b16.a_lsb), 32'h1);
        chk("w16.sh2.cnt", 32'(b16.cnt), 32'h2);
        set16(1,0,0,0,0, 16'h0, 16'h0); tick();
        set16(0,1,0,0,0, 16'h4001, 16'h0); tick();
        set16(0,0,0,1,0, 16'h0, 16'h0);
        exp16 = 16'h4001;
        for (int i = 1; i <= 18; i++) begin
            tick();
            exp16 = {exp16[15], exp16[15:1]};
            chk($sformatf("sat16.cnt%0d", i), 32'(b16.cnt), 32'((i < 16) ? i : 16));
            chk($sformatf("sat16.done%0d", i), 32'(b16.cnt_done), 32'(i >= 16));
        end
        chk("sat16.q", 32'(b16.q), 32'(exp16));
        set16(1,0,0,0,0, 16'h0, 16'h0); tick();
        chk("sat16.clr.cnt", 32'(b16.cnt), 32'h0);
        chk("sat16.clr.done", 32'(b16.cnt_done), 32'h0);
        set16(0,0,0,0,0, 16'h0, 16'h0);

        // Random stimulus against the reference model.
        set8(1,0,0,0,0,0, 8'h00, 8'h00); tick();
        m_q = 0; m_cnt = 0; m_lsb = 0; m_msb = 0;
        for (int n = 0; n < 400; n++) begin
            r_c0  = ($urandom_range(0, 15) == 0);
            r_c1  = ($urandom_range(0, 5) == 0);
            r_c2  = ($urandom_range(0, 5) == 0);
            r_c4  = ($urandom_range(0, 2) == 0);
            r_c6  = ($urandom_range(0, 2) == 0);
            r_shl = 1'($urandom);
            r_in  = 8'($urandom);
            r_sum = 8'($urandom);
            set8(r_c0, r_c1, r_c2, r_c4, r_c6, r_shl, r_in, r_sum);
            b8.c5 = 1'($urandom);
            #1;
            if (b8.c5) chk("rnd.obus", 32'(obus8), 32'(m_q));
            else if (m_q != 0)
                chk("rnd.obus_z", 32'((obus8 === zz8) || (obus8 === 8'h00)), 32'h1);
            model_step(r_c0, r_c1, r_c2, r_c4, r_c6, r_shl, r_in, r_sum);
            tick();
            chk8($sformatf("rnd%0d", n), 8'(m_q), m_cnt, 1'(m_lsb), 1'(m_msb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
